// File: rtl/tmss_bus_pkg.sv
// Shared definitions for the TMSS unlock initiator: bus addresses, signature
// words, FSM/step encodings, error codes and the per-step bus command table.
package tmss_bus_pkg;

    localparam logic [22:0] TMSS_SIG_HI_VA = 23'h50A000;
    localparam logic [22:0] TMSS_SIG_LO_VA = 23'h50A001;
    localparam logic [22:0] TMSS_BANK_VA   = 23'h50A080;

    localparam logic [15:0] TMSS_MAGIC_HI = 16'h5345;
    localparam logic [15:0] TMSS_MAGIC_LO = 16'h4741;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SETUP,
        BUS_STROBE,
        BUS_RELEASE
    } bus_state_t;

    typedef enum logic [2:0] {
        STEP_S0,
        STEP_S1,
        STEP_S2,
        STEP_S3,
        STEP_S4
    } step_t;

    typedef struct packed {
        logic [22:0] addr;
        logic        rw;
        logic [1:0]  ds_n;
        logic [15:0] wdata;
    } bus_cmd_t;

    // ds_n is {UDS, LDS}, active low; the select write only touches the low byte
    function automatic bus_cmd_t step_cmd(step_t s, logic bank);
        bus_cmd_t c;
        c.addr  = TMSS_SIG_HI_VA;
        c.rw    = 1'b0;
        c.ds_n  = 2'b00;
        c.wdata = TMSS_MAGIC_HI;
        case (s)
            STEP_S1: begin
                c.addr  = TMSS_SIG_LO_VA;
                c.wdata = TMSS_MAGIC_LO;
            end
            STEP_S2: begin
                c.rw    = 1'b1;
                c.wdata = 16'h0000;
            end
            STEP_S3: begin
                c.addr  = TMSS_SIG_LO_VA;
                c.rw    = 1'b1;
                c.wdata = 16'h0000;
            end
            STEP_S4: begin
                c.addr  = TMSS_BANK_VA;
                c.ds_n  = 2'b10;
                c.wdata = {15'h0000, bank};
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmss_bus_cycle.sv
// Single 68000-style bus cycle engine: SETUP, STROBE, RELEASE with a per-state
// DTACK timeout and read-data capture. A new cycle may chain straight from RELEASE.
module tmss_bus_cycle
    import tmss_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic [22:0] addr,
    input  logic        rw,
    input  logic [1:0]  ds_n,
    input  logic [15:0] wdata,
    input  logic        dtack_n,
    input  logic [15:0] rdata_in,
    output logic        as_n,
    output logic        uds_n,
    output logic        lds_n,
    output logic        bus_rw,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        data_out_en,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        timeout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    bus_state_t  state, state_next;
    logic [22:0] addr_q;
    logic        rw_q;
    logic [1:0]  ds_q;
    logic [15:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BUS_IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b1;
            ds_q     <= 2'b11;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                addr_q  <= addr;
                rw_q    <= rw;
                ds_q    <= ds_n;
                wdata_q <= wdata;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state == BUS_STROBE || state == BUS_RELEASE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == BUS_STROBE && !dtack_n && rw_q) begin
                rdata <= rdata_in;
            end
        end
    end

    // Both wait states share the counter; the limit check fires on the clock
    // that would otherwise be the TIMEOUT_CYCLES-th one spent waiting.
    always_comb begin
        state_next = state;
        ack        = 1'b0;
        timeout    = 1'b0;
        load       = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (go) begin
                    state_next = BUS_SETUP;
                    load       = 1'b1;
                end
            end
            BUS_SETUP: state_next = BUS_STROBE;
            BUS_STROBE: begin
                if (!dtack_n) begin
                    state_next = BUS_RELEASE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = BUS_IDLE;
                    timeout    = 1'b1;
                end
            end
            BUS_RELEASE: begin
                if (dtack_n) begin
                    ack = 1'b1;
                    if (go) begin
                        state_next = BUS_SETUP;
                        load       = 1'b1;
                    end else begin
                        state_next = BUS_IDLE;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_next = BUS_IDLE;
                    timeout    = 1'b1;
                end
            end
            default: state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        as_n        = (state != BUS_STROBE);
        uds_n       = (state == BUS_STROBE) ? ds_q[1] : 1'b1;
        lds_n       = (state == BUS_STROBE) ? ds_q[0] : 1'b1;
        bus_addr    = (state == BUS_IDLE) ? 23'h0 : addr_q;
        bus_rw      = (state == BUS_IDLE) ? 1'b1 : rw_q;
        bus_wdata   = (state == BUS_IDLE) ? 16'h0 : wdata_q;
        data_out_en = (state == BUS_SETUP || state == BUS_STROBE) && !rw_q;
    end

endmodule

// File: rtl/tmss_boot_master.sv
// TMSS unlock sequencer: walks the signature/select steps through tmss_bus_cycle.
// Define TMSS_BOOT_MASTER_VERIFY_EN to read back and check the signature before the select write.
module tmss_boot_master
    import tmss_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        start,
    input  logic        bank_sel,
    input  logic        DTACK,
    input  logic [15:0] VD_i,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [22:0] VA,
    output logic [15:0] VD_o,
    output logic        data_out_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err
);

    step_t       step, step_next, step_after, issue_step;
    logic        busy_next, done_next, bank_q, bank_next;
    logic [1:0]  err_next;
    logic        go, ack, timeout, verify_fail;
    logic [15:0] rdata;
    bus_cmd_t    issue_cmd;

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            step   <= STEP_S0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= ERR_NONE;
            bank_q <= 1'b0;
        end else begin
            step   <= step_next;
            busy   <= busy_next;
            done   <= done_next;
            err    <= err_next;
            bank_q <= bank_next;
        end
    end

    always_comb begin
        step_after = STEP_S4;
        case (step)
            STEP_S0: step_after = STEP_S1;
`ifdef TMSS_BOOT_MASTER_VERIFY_EN
            STEP_S1: step_after = STEP_S2;
`else
            STEP_S1: step_after = STEP_S4;
`endif
            STEP_S2: step_after = STEP_S3;
            default: step_after = STEP_S4;
        endcase
    end

    // Read steps only exist in the verify build, so this is constant-false otherwise
    assign verify_fail = (step == STEP_S2 && rdata != TMSS_MAGIC_HI) ||
                         (step == STEP_S3 && rdata != TMSS_MAGIC_LO);

    // go must be combinational so the engine chains RELEASE -> SETUP without a gap
    always_comb begin
        step_next  = step;
        busy_next  = busy;
        done_next  = 1'b0;
        err_next   = err;
        bank_next  = bank_q;
        go         = 1'b0;
        issue_step = STEP_S0;
        if (!busy) begin
            if (start) begin
                step_next = STEP_S0;
                busy_next = 1'b1;
                err_next  = ERR_NONE;
                bank_next = bank_sel;
                go        = 1'b1;
            end
        end else if (timeout) begin
            busy_next = 1'b0;
            err_next  = ERR_TIMEOUT;
        end else if (ack) begin
            if (verify_fail) begin
                busy_next = 1'b0;
                err_next  = ERR_VERIFY;
            end else if (step == STEP_S4) begin
                busy_next = 1'b0;
                done_next = 1'b1;
            end else begin
                step_next  = step_after;
                issue_step = step_after;
                go         = 1'b1;
            end
        end
    end

    assign issue_cmd = step_cmd(issue_step, bank_q);

    tmss_bus_cycle #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cycle (
        .clk        (MCLK),
        .rst_n      (RESET),
        .go         (go),
        .addr       (issue_cmd.addr),
        .rw         (issue_cmd.rw),
        .ds_n       (issue_cmd.ds_n),
        .wdata      (issue_cmd.wdata),
        .dtack_n    (DTACK),
        .rdata_in   (VD_i),
        .as_n       (AS),
        .uds_n      (UDS),
        .lds_n      (LDS),
        .bus_rw     (RW),
        .bus_addr   (VA),
        .bus_wdata  (VD_o),
        .data_out_en(data_out_en),
        .ack        (ack),
        .rdata      (rdata),
        .timeout    (timeout)
    );

endmodule

// File: doc/tmss_boot_master.md
# tmss_boot_master

Bus initiator that runs the TMSS unlock sequence on the 68000-side bus. It writes the "SEGA" signature to the TMSS signature latches and then writes the cartridge/boot-ROM select bit. It sits beside the CPU as an alternate bus master, used by boot-bypass and by the system bench. It drives 68000-style strobes and completes each cycle on DTACK, acting as the initiator counterpart of the TMSS responder.

## Interface
- TIMEOUT_CYCLES, 255: max clocks spent waiting for any DTACK edge before abort (8-bit counter, 1..255)
- MCLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- start  in  1  request sequence; sampled only in IDLE
- bank_sel  in  1  value written to bit 0 of the select register (1 = cartridge)
- DTACK  in  1  active-low cycle acknowledge
- VD_i  in  16  read data
- AS  out  1  active-low address strobe
- UDS  out  1  active-low upper data strobe
- LDS  out  1  active-low lower data strobe
- RW  out  1  1 = read, 0 = write
- VA  out  23  word address (byte address >> 1)
- VD_o  out  16  write data
- data_out_en  out  1  drive VD_o onto the bus
- busy  out  1  sequence in progress
- done  out  1  one-clock pulse on successful completion
- err  out  2  0 none, 1 DTACK timeout, 2 verify mismatch; held until the next accepted start

## Operation
- Step list, executed in order:
  - S0: write 0x5345 to VA 0x50A000 (UDS=LDS=0)
  - S1: write 0x4741 to VA 0x50A001 (UDS=LDS=0)
  - [S2/S3: readback, see Configuration]
  - S4: write {15'h0, bank_sel} to VA 0x50A080 (LDS=0, UDS=1)
- bank_sel is captured when start is accepted.
- FSM states:
  - IDLE: start=1 → SETUP with step=S0; busy=1; err cleared.
  - SETUP: 1 clk. VA, RW and VD_o are valid. data_out_en=1 on writes. Strobes stay high.
  - STROBE: AS=0 and the step's DS=0. Stay until DTACK is sampled 0, then → RELEASE. On a read step, VD_i is captured on that same edge.
  - RELEASE: AS/UDS/LDS=1, data_out_en=0; VA and RW are held. Stay until DTACK is sampled 1. Then either → SETUP for the next step, or → IDLE with done=1 for one clock after the last step.
- Timeout:
  - An 8-bit counter clears on entry to STROBE and on entry to RELEASE, and increments each clock spent in that state.
  - When the counter reaches TIMEOUT_CYCLES: err=1, strobes go high, → IDLE with no done pulse.
- start while busy is ignored. start held high in IDLE after completion relaunches the sequence.
- No other address is ever driven. VA=0 and RW=1 in IDLE.

## Timing
- Reset values: AS=UDS=LDS=RW=1, VA=0, VD_o=0, data_out_en=0, busy=0, done=0, err=0, FSM=IDLE.
- Reset mid-operation: all outputs return to reset values at the reset edge; no partial cycle is completed.
- start sampled at edge t → SETUP outputs at t+1, strobes low at t+2.
- Zero-wait responder (DTACK low during STROBE, high during RELEASE): 3 clocks per step.
- Unlock without verify = 9 clocks from start edge to the last RELEASE. done is asserted on the following clock.
- DTACK already low when entering STROBE is accepted on the first STROBE clock.
- DTACK held low through RELEASE keeps the FSM in RELEASE until it rises or the timeout fires.
- Timeout fires at exactly TIMEOUT_CYCLES clocks of waiting within a single state.

## Configuration
- TMSS_BOOT_MASTER_VERIFY_EN defined:
  - S2 reads VA 0x50A000 and S3 reads VA 0x50A001 (UDS=LDS=0, RW=1, data_out_en=0).
  - Captured data must equal 0x5345 and 0x4741. Otherwise err=2 and → IDLE immediately after that step's RELEASE; S4 is skipped.
- Undefined: S2/S3 are absent and S1 is followed directly by S4.

## Structure
- Package tmss_bus_pkg holds:
  - address constants TMSS_SIG_HI_VA=23'h50A000, TMSS_SIG_LO_VA=23'h50A001, TMSS_BANK_VA=23'h50A080
  - magic words 16'h5345 and 16'h4741
  - FSM state enum
  - step enum
  - err code constants
- Sub-module tmss_bus_cycle is the single-cycle engine: SETUP/STROBE/RELEASE, timeout counter, read capture. It takes addr/rw/ds/wdata/go and returns ack/rdata/timeout. The top level holds only the step sequencer.

## Test plan
- Zero-wait responder, bank_sel=1, verify off → writes 5345@50A000, 4741@50A001, 0001@50A080 (LDS only); done on clock 10 after the start edge; err=0.
- Responder with 3 wait states per cycle → each STROBE lasts 4 clocks; same data and addresses; done asserted; err=0.
- DTACK stuck high, TIMEOUT_CYCLES=16 → AS low for exactly 16 clocks, then all strobes high; err=1; no done; no further cycles.
- Verify on, responder returns 0x5345 then 0x0000 → err=2 after S3; no write to 50A080.
- RESET low during S1 STROBE → next clock AS=UDS=LDS=1, busy=0, VA=0. A subsequent start restarts at S0.
- start pulsed during S1 → ignored; exactly one sequence and one done pulse.
